wb_dsp_equation_scheduler: RTL and testbench

//  Round-robin scheduler sitting between the begin_equation trigger inputs and the

---
 rtl/wb_dsp_equation_scheduler.sv | 139 +++++++++++++
 tb/tb_wb_dsp_equation_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dsp_equation_scheduler.sv
// Round-robin equation scheduler: captures begin_equation triggers as pending requests,
// issues one equation at a time to the equation SM and keeps sticky done/error/overrun status.
module wb_dsp_equation_scheduler #(
  parameter int NUM_EQ    = 4,
  parameter int AW        = 32,
  parameter int TIMEOUT_W = 16
) (
  input  logic                      wb_clk,
  input  logic                      wb_rst,
  input  logic [NUM_EQ-1:0]         begin_equation,
  input  logic [NUM_EQ*AW-1:0]      eq_address,
  input  logic [NUM_EQ-1:0]         eq_enable,
  input  logic [TIMEOUT_W-1:0]      timeout_limit,
  input  logic                      sm_done_i,
  input  logic                      sm_error_i,
  input  logic                      status_clr_i,
  output logic                      start_o,
  output logic [AW-1:0]             start_addr_o,
  output logic [$clog2(NUM_EQ)-1:0] start_id_o,
  output logic                      abort_o,
  output logic                      busy_o,
  output logic [NUM_EQ-1:0]         pending_o,
  output logic [NUM_EQ-1:0]         done_flags_o,
  output logic [NUM_EQ-1:0]         err_flags_o,
  output logic [NUM_EQ-1:0]         overrun_o,
  output logic                      interrupt
);

  localparam int ID_W = $clog2(NUM_EQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_COMPLETE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [NUM_EQ-1:0]    r_beg_q;
  logic [ID_W-1:0]      r_rr_ptr;
  logic [TIMEOUT_W-1:0] r_timer;
  logic [NUM_EQ-1:0]    w_edge;
  logic [NUM_EQ-1:0]    w_req;
  logic [NUM_EQ-1:0]    w_issue_clr;
  logic [NUM_EQ-1:0]    w_set_done;
  logic [NUM_EQ-1:0]    w_set_err;
  logic [ID_W-1:0]      w_grant;
  logic [ID_W-1:0]      w_rr_next;
  logic                 w_found;
  logic                 w_timeout;

  assign w_edge    = begin_equation & ~r_beg_q & eq_enable;
  assign w_req     = pending_o & eq_enable;
  assign w_timeout = (timeout_limit != '0) && (r_timer == timeout_limit - TIMEOUT_W'(1));
  assign w_rr_next = (w_grant == ID_W'(NUM_EQ - 1)) ? '0 : w_grant + 1'b1;
  assign interrupt = |(done_flags_o | err_flags_o | overrun_o);

  // Search starts at the round-robin pointer and wraps, so the slot just served goes last.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int k = 0; k < NUM_EQ; k++) begin
      if (!w_found && w_req[(int'(r_rr_ptr) + k) % NUM_EQ]) begin
        w_found = 1'b1;
        w_grant = ID_W'((int'(r_rr_ptr) + k) % NUM_EQ);
      end
    end
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Pulses are masked by reset so a reset cycle never leaks a start or abort.
  always_comb begin
    w_next      = r_state;
    start_o     = 1'b0;
    abort_o     = 1'b0;
    busy_o      = 1'b0;
    w_issue_clr = '0;
    w_set_done  = '0;
    w_set_err   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        start_o                 = wb_rst;
        busy_o                  = 1'b1;
        w_issue_clr[start_id_o] = 1'b1;
        w_next                  = S_WAIT;
      end
      S_WAIT: begin
        busy_o = 1'b1;
        if (sm_done_i) begin
          w_set_done[start_id_o] = 1'b1;
          w_next                 = S_COMPLETE;
        end else if (sm_error_i) begin
          w_set_err[start_id_o] = 1'b1;
          w_next                = S_COMPLETE;
        end else if (w_timeout) begin
          abort_o               = wb_rst;
          w_set_err[start_id_o] = 1'b1;
          w_next                = S_COMPLETE;
        end
      end
      S_COMPLETE: w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // A new trigger beats the issue-time clear, so it re-queues without counting as overrun.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst) begin
      r_beg_q      <= '0;
      r_rr_ptr     <= '0;
      r_timer      <= '0;
      pending_o    <= '0;
      done_flags_o <= '0;
      err_flags_o  <= '0;
      overrun_o    <= '0;
      start_id_o   <= '0;
      start_addr_o <= '0;
    end else begin
      r_beg_q      <= begin_equation;
      pending_o    <= w_edge | (pending_o & eq_enable & ~w_issue_clr);
      overrun_o    <= (overrun_o & ~{NUM_EQ{status_clr_i}}) | (w_edge & pending_o & ~w_issue_clr);
      done_flags_o <= (done_flags_o & ~{NUM_EQ{status_clr_i}}) | w_set_done;
      err_flags_o  <= (err_flags_o & ~{NUM_EQ{status_clr_i}}) | w_set_err;
      if (r_state == S_IDLE && w_found) begin
        start_id_o   <= w_grant;
        start_addr_o <= eq_address[int'(w_grant)*AW +: AW];
        r_rr_ptr     <= w_rr_next;
      end
      if (r_state == S_ISSUE)
        r_timer <= '0;
      else if (r_state == S_WAIT && r_timer != '1)
        r_timer <= r_timer + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_dsp_equation_scheduler.sv
// Bench for wb_dsp_equation_scheduler: a directed vector table, corner-case sequences and
// randomized traffic, all compared every cycle against a timestamp-based reference model.
module tb_wb_dsp_equation_scheduler;

  localparam int NEQ = 4;
  localparam int AW  = 32;
  localparam int TW  = 16;

  logic              clk = 1'b0;
  logic              rstN;
  logic [NEQ-1:0]    beg;
  logic [NEQ*AW-1:0] addrBus;
  logic [NEQ-1:0]    en;
  logic [TW-1:0]     lim;
  logic              smDone, smErr, clr;
  logic              start_o, abort_o, busy_o, interrupt;
  logic [AW-1:0]     start_addr_o;
  logic [1:0]        start_id_o;
  logic [NEQ-1:0]    pending_o, done_flags_o, err_flags_o, overrun_o;

  always #5 clk = ~clk;

  wb_dsp_equation_scheduler #(.NUM_EQ(NEQ), .AW(AW), .TIMEOUT_W(TW)) dut (
    .wb_clk(clk), .wb_rst(rstN), .begin_equation(beg), .eq_address(addrBus),
    .eq_enable(en), .timeout_limit(lim), .sm_done_i(smDone), .sm_error_i(smErr),
    .status_clr_i(clr), .start_o(start_o), .start_addr_o(start_addr_o),
    .start_id_o(start_id_o), .abort_o(abort_o), .busy_o(busy_o), .pending_o(pending_o),
    .done_flags_o(done_flags_o), .err_flags_o(err_flags_o), .overrun_o(overrun_o),
    .interrupt(interrupt)
  );

  typedef struct {
    logic [NEQ-1:0] beg;
    logic           done;
    logic           clr;
    logic           eStart;
    logic           eBusy;
    logic [AW-1:0]  eAddr;
    logic [NEQ-1:0] ePend;
    logic [NEQ-1:0] eDone;
    logic           eIrq;
  } vec_t;

  vec_t vecs[$];
  vec_t curVec;
  bit   tableMode;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  // Reference model: a job is described by its grant slot and the cycle of its start pulse.
  bit [NEQ-1:0] mPrev, mPend, mDone, mErr, mOvr;
  int           mRr, mId, mT0, mFree, mOutId;
  bit           mActive;
  logic [AW-1:0] mOutAddr;

  bit autoDone;
  int autoDelay;
  int startIds[$];
  int startCycles[$];
  int abortCycles[$];

  task automatic modelReset();
    mPrev = '0; mPend = '0; mDone = '0; mErr = '0; mOvr = '0;
    mRr = 0; mId = 0; mT0 = 0; mFree = 0; mOutId = 0; mActive = 1'b0; mOutAddr = '0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d actual=%0h required=%0h", name, n, act, exp);
    end
  endtask

  task automatic applyStimulus();
    bit             waiting, eStart, eAbort, eBusy, ending, found;
    int             elapsed, g, idx;
    bit [NEQ-1:0]   edgeV, iss, setD, setE;
    waiting = mActive && (n > mT0);
    elapsed = waiting ? (n - mT0 - 1) : 0;
    if (elapsed > 65535) elapsed = 65535;
    if (autoDone) smDone = waiting && (elapsed == autoDelay);
    #2;
    eBusy  = mActive && (n >= mT0);
    eStart = mActive && (n == mT0) && rstN;
    eAbort = waiting && !smDone && !smErr && (lim != 0) && (elapsed == int'(lim) - 1) && rstN;
    checkOutput("start", start_o, eStart);
    checkOutput("abort", abort_o, eAbort);
    checkOutput("busy", busy_o, eBusy);
    checkOutput("id", start_id_o, mOutId);
    checkOutput("addr", start_addr_o, mOutAddr);
    checkOutput("pending", pending_o, mPend);
    checkOutput("doneFlags", done_flags_o, mDone);
    checkOutput("errFlags", err_flags_o, mErr);
    checkOutput("overrun", overrun_o, mOvr);
    checkOutput("irq", interrupt, |(mDone | mErr | mOvr));
    if (tableMode) begin
      checkOutput("tblStart", start_o, curVec.eStart);
      checkOutput("tblBusy", busy_o, curVec.eBusy);
      checkOutput("tblAddr", start_addr_o, curVec.eAddr);
      checkOutput("tblPend", pending_o, curVec.ePend);
      checkOutput("tblDone", done_flags_o, curVec.eDone);
      checkOutput("tblIrq", interrupt, curVec.eIrq);
    end
    if (start_o === 1'b1) begin startIds.push_back(int'(start_id_o)); startCycles.push_back(n); end
    if (abort_o === 1'b1) abortCycles.push_back(n);

    if (!rstN) modelReset();
    else begin
      ending = waiting && (smDone || smErr || eAbort);
      setD = '0; setE = '0; iss = '0;
      if (waiting && smDone) setD[mId] = 1'b1;
      else if (ending) setE[mId] = 1'b1;
      if (eStart) iss[mId] = 1'b1;
      edgeV = beg & ~mPrev & en;
      found = 1'b0; g = 0;
      if (!mActive && n >= mFree) begin
        for (int k = 0; k < NEQ; k++) begin
          idx = (mRr + k) % NEQ;
          if (!found && mPend[idx] && en[idx]) begin found = 1'b1; g = idx; end
        end
      end
      if (found) begin
        mActive = 1'b1; mId = g; mT0 = n + 1; mRr = (g + 1) % NEQ;
        mOutId = g; mOutAddr = addrBus[g*AW +: AW];
      end
      if (ending) begin mActive = 1'b0; mFree = n + 2; end
      mOvr  = (mOvr & ~{NEQ{clr}}) | (edgeV & mPend & ~iss);
      mDone = (mDone & ~{NEQ{clr}}) | setD;
      mErr  = (mErr & ~{NEQ{clr}}) | setE;
      mPend = edgeV | (mPend & en & ~iss);
      mPrev = beg;
    end
    @(posedge clk);
    @(negedge clk);
    n++;
  endtask

  task automatic quiet();
    beg = '0; smDone = 1'b0; smErr = 1'b0; clr = 1'b0;
  endtask

  task automatic applyReset();
    quiet();
    rstN = 1'b0;
    applyStimulus();
    rstN = 1'b1;
    startIds.delete(); startCycles.delete(); abortCycles.delete();
  endtask

  task automatic addVec(input logic [NEQ-1:0] b, input logic d, input logic c, input logic s,
                        input logic bz, input logic [AW-1:0] a, input logic [NEQ-1:0] p,
                        input logic [NEQ-1:0] df, input logic irq);
    vec_t v;
    v.beg = b; v.done = d; v.clr = c; v.eStart = s; v.eBusy = bz;
    v.eAddr = a; v.ePend = p; v.eDone = df; v.eIrq = irq;
    vecs.push_back(v);
  endtask

  initial begin
    rstN = 1'b0; en = '0; lim = '0; autoDone = 1'b0; autoDelay = 0; tableMode = 1'b0;
    quiet();
    addrBus = {32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    @(posedge clk);
    @(negedge clk);
    modelReset();
    rstN = 1'b1;

    // Single equation on slot 0: trigger, start two clocks later, done five clocks after start.
    addVec(4'b0000, 0, 0, 0, 0, 32'h0, 4'b0000, 4'b0000, 0);
    addVec(4'b0001, 0, 0, 0, 0, 32'h0, 4'b0000, 4'b0000, 0);
    addVec(4'b0001, 0, 0, 0, 0, 32'h0, 4'b0001, 4'b0000, 0);
    addVec(4'b0000, 0, 0, 1, 1, 32'h1000, 4'b0001, 4'b0000, 0);
    for (int i = 0; i < 4; i++) addVec(4'b0000, 0, 0, 0, 1, 32'h1000, 4'b0000, 4'b0000, 0);
    addVec(4'b0000, 1, 0, 0, 1, 32'h1000, 4'b0000, 4'b0000, 0);
    addVec(4'b0000, 0, 0, 0, 0, 32'h1000, 4'b0000, 4'b0001, 1);
    addVec(4'b0000, 0, 0, 0, 0, 32'h1000, 4'b0000, 4'b0001, 1);
    addVec(4'b0000, 0, 1, 0, 0, 32'h1000, 4'b0000, 4'b0001, 1);
    addVec(4'b0000, 0, 0, 0, 0, 32'h1000, 4'b0000, 4'b0000, 0);
    en = 4'b0001;
    tableMode = 1'b1;
    foreach (vecs[i]) begin
      curVec = vecs[i];
      beg = curVec.beg; smDone = curVec.done; clr = curVec.clr;
      applyStimulus();
    end
    tableMode = 1'b0;

    // Round robin: all four at once, then 0 and 3 with the pointer back at 0.
    applyReset();
    en = 4'hF; lim = '0; autoDone = 1'b1; autoDelay = 2;
    beg = 4'hF; applyStimulus(); beg = '0;
    repeat (40) applyStimulus();
    checkOutput("rrCount", startIds.size(), 4);
    for (int i = 0; i < startIds.size(); i++) checkOutput("rrOrder", startIds[i], i);
    startIds.delete();
    beg = 4'b1001; applyStimulus(); beg = '0;
    repeat (20) applyStimulus();
    checkOutput("rrPairCount", startIds.size(), 2);
    if (startIds.size() == 2) begin
      checkOutput("rrPairFirst", startIds[0], 0);
      checkOutput("rrPairSecond", startIds[1], 3);
    end

    // Watchdog: two queued jobs, neither answered.
    applyReset();
    autoDone = 1'b0; lim = 16'd8;
    beg = 4'b0110; applyStimulus(); beg = '0;
    repeat (30) applyStimulus();
    checkOutput("toStarts", startIds.size(), 2);
    checkOutput("toAborts", abortCycles.size(), 2);
    if (startCycles.size() >= 1 && abortCycles.size() >= 1)
      checkOutput("toDelay", abortCycles[0] - startCycles[0], 8);
    if (startIds.size() == 2) checkOutput("toNextId", startIds[1], 2);
    checkOutput("toErr", err_flags_o, 4'b0110);

    // Overrun on slot 2 while slot 0 is busy; disabled slot 1 is never queued.
    applyReset();
    lim = '0; en = 4'b1101;
    beg = 4'b0001; applyStimulus(); beg = '0;
    repeat (3) applyStimulus();
    beg = 4'b0110; applyStimulus(); beg = '0; applyStimulus();
    beg = 4'b0110; applyStimulus(); beg = '0; applyStimulus();
    checkOutput("ovrFlag", overrun_o, 4'b0100);
    checkOutput("ovrPend", pending_o, 4'b0100);
    startIds.delete();
    smDone = 1'b1; applyStimulus(); smDone = 1'b0;
    autoDone = 1'b1; autoDelay = 1;
    repeat (12) applyStimulus();
    checkOutput("enCount", startIds.size(), 1);
    if (startIds.size() == 1) checkOutput("enId", startIds[0], 2);

    // Collisions: done with clear, then done with error.
    applyReset();
    autoDone = 1'b0; en = 4'hF;
    beg = 4'b0001; applyStimulus(); beg = '0;
    repeat (3) applyStimulus();
    smDone = 1'b1; clr = 1'b1; applyStimulus(); smDone = 1'b0; clr = 1'b0;
    applyStimulus();
    checkOutput("doneVsClr", done_flags_o, 4'b0001);
    beg = 4'b0010; applyStimulus(); beg = '0;
    repeat (3) applyStimulus();
    smDone = 1'b1; smErr = 1'b1; applyStimulus(); smDone = 1'b0; smErr = 1'b0;
    applyStimulus();
    checkOutput("doneVsErrD", done_flags_o, 4'b0011);
    checkOutput("doneVsErrE", err_flags_o, 4'b0000);

    // Reset landing exactly on the watchdog expiry cycle.
    applyReset();
    lim = 16'd8;
    beg = 4'b0100; applyStimulus(); beg = '0;
    repeat (9) applyStimulus();
    rstN = 1'b0; applyStimulus(); rstN = 1'b1;
    applyStimulus();
    checkOutput("rstAborts", abortCycles.size(), 0);
    checkOutput("rstBusy", busy_o, 1'b0);
    checkOutput("rstErr", err_flags_o, 4'b0000);
    checkOutput("rstPend", pending_o, 4'b0000);

    // Random traffic.
    applyReset();
    en = 4'hF;
    for (int c = 0; c < 2500; c++) begin
      beg    = beg ^ (4'($urandom) & 4'($urandom));
      smDone = ($urandom_range(0, 9) == 0);
      smErr  = ($urandom_range(0, 14) == 0);
      clr    = ($urandom_range(0, 39) == 0);
      rstN   = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 49) == 0) en = 4'($urandom);
      if ($urandom_range(0, 99) == 0)
        lim = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(3, 12));
      if ($urandom_range(0, 63) == 0) addrBus[$urandom_range(0, 3)*AW +: AW] = $urandom;
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
